// File: rtl/sa_controller.sv
// rtl/sa_controller.sv - sequencer for an output-stationary systolic MAC array
// Clears the PEs, runs the skewed compute window, then drains one psum column per handshake.
module sa_controller #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int K_WIDTH   = 8,
  parameter int CNT_WIDTH = 10
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_start,
  input  logic [K_WIDTH-1:0]       i_k_len,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_reg_clear,
  output logic                     o_pe_en,
  output logic                     o_psum_out_en,
  output logic [CNT_WIDTH-1:0]     o_feed_cnt,
  output logic [ROWS-1:0]          o_row_feed_en,
  output logic [COLS-1:0]          o_col_feed_en,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [$clog2(COLS)-1:0]  o_out_col
);

  localparam int COL_W = $clog2(COLS);
  // Last compute index is W-1 = K + ROWS + COLS - 3; the skew part is constant.
  localparam logic [CNT_WIDTH-1:0] SKEW_LAST = CNT_WIDTH'(ROWS + COLS - 3);
  localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [K_WIDTH-1:0]   k_q;
  logic [CNT_WIDTH-1:0] t_q;
  logic [COL_W-1:0]     d_q;

  logic [CNT_WIDTH-1:0] k_ext;
  logic [CNT_WIDTH-1:0] t_last;
  logic                 in_compute;
  logic                 in_drain;

  assign k_ext      = CNT_WIDTH'(k_q);
  assign t_last     = k_ext + SKEW_LAST;
  assign in_compute = (state_q == S_COMPUTE);
  assign in_drain   = (state_q == S_DRAIN);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      d_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            k_q     <= i_k_len;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          t_q     <= '0;
          d_q     <= '0;
          state_q <= (k_q != '0) ? S_COMPUTE : S_DRAIN;
        end
        S_COMPUTE: begin
          if (t_q == t_last) begin
            d_q     <= '0;
            state_q <= S_DRAIN;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (i_out_ready) begin
            if (d_q == LAST_COL) begin
              state_q <= S_DONE;
            end else begin
              d_q <= d_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_reg_clear   = (state_q == S_CLEAR);
  assign o_pe_en       = in_compute;
  assign o_out_valid   = in_drain;
  assign o_out_col     = in_drain ? d_q : '0;
  assign o_feed_cnt    = in_compute ? t_q : '0;
  // Only the drain shift depends on the sink's ready in the same cycle.
  assign o_psum_out_en = in_drain & i_out_ready;

  // Row r and column c see operand t-r / t-c, valid for K consecutive cycles.
  always_comb begin
    o_row_feed_en = '0;
    for (int r = 0; r < ROWS; r++) begin
      o_row_feed_en[r] = in_compute && (t_q >= CNT_WIDTH'(r)) &&
                         (t_q < CNT_WIDTH'(r) + k_ext);
    end
  end

  always_comb begin
    o_col_feed_en = '0;
    for (int c = 0; c < COLS; c++) begin
      o_col_feed_en[c] = in_compute && (t_q >= CNT_WIDTH'(c)) &&
                         (t_q < CNT_WIDTH'(c) + k_ext);
    end
  end

endmodule

// File: tb/tb_sa_controller.sv
// tb/tb_sa_controller.sv - directed bench for sa_controller with a small PE-array model
module tb_sa_controller;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 8;
  localparam int CW   = 10;

  logic            i_clk = 1'b0;
  logic            i_nrst;
  logic            i_start;
  logic [KW-1:0]   i_k_len;
  logic            o_busy, o_done, o_reg_clear, o_pe_en, o_psum_out_en;
  logic [CW-1:0]   o_feed_cnt;
  logic [ROWS-1:0] o_row_feed_en;
  logic [COLS-1:0] o_col_feed_en;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [1:0]      o_out_col;

  always #5 i_clk = ~i_clk;

  sa_controller #(.ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_k_len(i_k_len),
    .o_busy(o_busy), .o_done(o_done), .o_reg_clear(o_reg_clear), .o_pe_en(o_pe_en),
    .o_psum_out_en(o_psum_out_en), .o_feed_cnt(o_feed_cnt),
    .o_row_feed_en(o_row_feed_en), .o_col_feed_en(o_col_feed_en),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_col(o_out_col)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int A [ROWS][256];
  int B [256][COLS];
  int acc [ROWS][COLS];
  int a_reg [ROWS][COLS];
  int b_reg [ROWS][COLS];
  int drained [COLS][ROWS];
  int n_drained;

  logic [31:0] row3_hist, col0_hist;
  int          max_cnt;

  function automatic int get_a(int r, int kk);
    return (kk >= 0 && kk < 256) ? A[r][kk] : 999;
  endfunction

  function automatic int get_b(int kk, int c);
    return (kk >= 0 && kk < 256) ? B[kk][c] : 999;
  endfunction

  function automatic int exp_psum(int r, int c, int k);
    int s = 0;
    for (int i = 0; i < k; i++) s += A[r][i] * B[i][c];
    return s;
  endfunction

  // Output-stationary array: operands flow right/down one PE per cycle; drain shifts toward column COLS-1.
  always @(posedge i_clk) begin
    int a_in, b_in;
    if (o_reg_clear) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          acc[r][c] <= 0; a_reg[r][c] <= 0; b_reg[r][c] <= 0;
        end
      n_drained <= 0;
    end else if (o_pe_en) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          if (c == 0) a_in = o_row_feed_en[r] ? get_a(r, int'(o_feed_cnt) - r) : 0;
          else        a_in = a_reg[r][c-1];
          if (r == 0) b_in = o_col_feed_en[c] ? get_b(int'(o_feed_cnt) - c, c) : 0;
          else        b_in = b_reg[r-1][c];
          acc[r][c]   <= acc[r][c] + a_in * b_in;
          a_reg[r][c] <= a_in;
          b_reg[r][c] <= b_in;
        end
    end else if (o_psum_out_en) begin
      for (int r = 0; r < ROWS; r++) begin
        if (n_drained < COLS) drained[n_drained][r] <= acc[r][COLS-1];
        for (int c = COLS - 1; c > 0; c--) acc[r][c] <= acc[r][c-1];
        acc[r][0] <= 0;
      end
      n_drained <= n_drained + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, o_busy, 0);
    chk({tag, ".done"}, o_done, 0);
    chk({tag, ".reg_clear"}, o_reg_clear, 0);
    chk({tag, ".pe_en"}, o_pe_en, 0);
    chk({tag, ".psum_out_en"}, o_psum_out_en, 0);
    chk({tag, ".feed_cnt"}, o_feed_cnt, 0);
    chk({tag, ".row_feed_en"}, o_row_feed_en, 0);
    chk({tag, ".col_feed_en"}, o_col_feed_en, 0);
    chk({tag, ".out_valid"}, o_out_valid, 0);
    chk({tag, ".out_col"}, o_out_col, 0);
  endtask

  // Starts a job at edge 0 and checks every cycle up to the hand-computed done cycle.
  task automatic run_job(input int k, input int stall_d, input int stall_n,
                         input int done_cyc, input bit noise);
    int w = k + ROWS + COLS - 2;
    int ds = (k > 0) ? w + 2 : 2;
    int d_exp = 0;
    int stall_left = stall_n;
    int t;
    bit rdy, in_drain, exp_pe;
    logic [ROWS-1:0] er;
    logic [COLS-1:0] ec;
    i_k_len = KW'(k);
    i_start = 1'b1;
    i_out_ready = 1'b1;
    cyc = 0;
    step();
    i_start = 1'b0;
    max_cnt = 0; row3_hist = '0; col0_hist = '0;
    while (1) begin
      in_drain = (cyc >= ds) && (d_exp < COLS);
      rdy = !(in_drain && d_exp == stall_d && stall_left > 0);
      i_out_ready = rdy;
      if (noise) begin
        i_start = (cyc % 3 == 0) || (cyc == done_cyc);
        i_k_len = KW'($urandom_range(0, 255));
      end
      #1;
      exp_pe = (k > 0) && (cyc >= 2) && (cyc <= w + 1);
      t = exp_pe ? cyc - 2 : 0;
      for (int r = 0; r < ROWS; r++) er[r] = exp_pe && (t >= r) && (t < r + k);
      for (int c = 0; c < COLS; c++) ec[c] = exp_pe && (t >= c) && (t < c + k);
      chk("busy", o_busy, 1);
      chk("reg_clear", o_reg_clear, (cyc == 1) ? 1 : 0);
      chk("pe_en", o_pe_en, exp_pe ? 1 : 0);
      chk("feed_cnt", o_feed_cnt, t);
      chk("row_feed_en", o_row_feed_en, er);
      chk("col_feed_en", o_col_feed_en, ec);
      chk("out_valid", o_out_valid, in_drain ? 1 : 0);
      chk("out_col", o_out_col, in_drain ? d_exp : 0);
      chk("psum_out_en", o_psum_out_en, (in_drain && rdy) ? 1 : 0);
      chk("done", o_done, (cyc == done_cyc) ? 1 : 0);
      if (o_pe_en === 1'b1) begin
        if (o_feed_cnt < 32) begin
          row3_hist[o_feed_cnt[4:0]] = o_row_feed_en[3];
          col0_hist[o_feed_cnt[4:0]] = o_col_feed_en[0];
        end
        if (int'(o_feed_cnt) > max_cnt) max_cnt = int'(o_feed_cnt);
      end
      if (in_drain) begin
        if (rdy) d_exp++;
        else stall_left--;
      end
      if (cyc >= done_cyc) break;
      step();
    end
    i_start = 1'b0;
    i_out_ready = 1'b0;
    step();
    chk("idle_after_done.busy", o_busy, 0);
    chk("idle_after_done.reg_clear", o_reg_clear, 0);
    chk("drain_count", n_drained, COLS);
    for (int d = 0; d < COLS; d++)
      for (int r = 0; r < ROWS; r++)
        chk($sformatf("psum[d%0d][r%0d]", d, r), drained[d][r], exp_psum(r, COLS - 1 - d, k));
  endtask

  initial begin
    bit seen_done;
    for (int r = 0; r < ROWS; r++)
      for (int kk = 0; kk < 256; kk++) A[r][kk] = (r * 7 + kk * 3 + 1) % 11;
    for (int kk = 0; kk < 256; kk++)
      for (int c = 0; c < COLS; c++) B[kk][c] = (kk * 5 + c * 2 + 3) % 13;

    i_nrst = 1'b0; i_start = 1'b0; i_k_len = '0; i_out_ready = 1'b0;
    step(); step();
    chk_all_zero("reset");
    i_nrst = 1'b1;
    step();

    // K=3 nominal: W=9, done at cycle 15.
    run_job(3, -1, 0, 15, 1'b0);
    chk("row3_window", row3_hist, 32'b111000);
    chk("col0_window", col0_hist, 32'b000111);

    // Back-pressure: ready low 3 cycles at d=1 delays done by 3.
    run_job(3, 1, 3, 18, 1'b0);

    // K=0: compute skipped, done at cycle 6, all psums zero.
    run_job(0, -1, 0, 6, 1'b0);

    // Reset in the middle of COMPUTE.
    i_k_len = 8'd3; i_start = 1'b1; i_out_ready = 1'b1;
    step();
    i_start = 1'b0;
    repeat (4) step();
    chk("pre_abort.pe_en", o_pe_en, 1);
    #2;
    i_nrst = 1'b0;
    #1;
    chk_all_zero("abort");
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 2) i_nrst = 1'b1;
      if (o_done === 1'b1) seen_done = 1'b1;
    end
    chk("no_done_after_abort", seen_done, 0);
    chk("idle_after_abort.busy", o_busy, 0);

    // K=2 clean job with start pulses and k_len churn while busy.
    run_job(2, -1, 0, 14, 1'b1);

    // K=255: W=261, feed counter peaks at 260, done at cycle 267.
    run_job(255, -1, 0, 267, 1'b0);
    chk("max_feed_cnt", max_cnt, 260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
